// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output FIFO slice: default sizes, the sample
// type and the occupancy FSM encoding.
package fir_pkg;

   localparam int NB_DEFAULT    = 11;
   localparam int DEPTH_DEFAULT = 8;
   localparam int DROP_W        = 16;

   typedef logic [NB_DEFAULT-1:0] sample_t;

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_FULL   = 2'd2
   } occ_state_t;

endpackage

// File: rtl/fir_out_fifo_if.sv
// Bundle between the FIR output FIFO (slave) and its producer/consumer side (master).
interface fir_out_fifo_if
   import fir_pkg::*;
#(
   parameter int NB    = NB_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT
);

   localparam int LW = $clog2(DEPTH) + 1;

   logic [NB-1:0]     DIN;
   logic              VIN;
   logic [NB-1:0]     DOUT;
   logic              VOUT;
   logic              READY;
   logic [LW-1:0]     LEVEL;
   logic              OVF;
   logic [DROP_W-1:0] DROP_CNT;

   modport master (
      output DIN, VIN, READY,
      input  DOUT, VOUT, LEVEL, OVF, DROP_CNT
   );

   modport slave (
      input  DIN, VIN, READY,
      output DOUT, VOUT, LEVEL, OVF, DROP_CNT
   );

endinterface

// File: rtl/fir_fifo_mem.sv
// DEPTH x NB register file for the output FIFO: one synchronous write port and
// one asynchronous read port. Contents are intentionally not reset.
module fir_fifo_mem
   import fir_pkg::*;
#(
   parameter int NB    = NB_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          CLK,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [NB-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [NB-1:0] rdata
);

   logic [NB-1:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fir_out_fifo.sv
// Show-ahead output FIFO behind the FIR filter: no backpressure toward the
// filter, so overflowing samples are dropped and counted.
module fir_out_fifo
   import fir_pkg::*;
#(
   parameter int NB    = NB_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input logic           CLK,
   input logic           RST,
   fir_out_fifo_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   occ_state_t        state;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     rd_ptr_nxt;
   logic [LW-1:0]     level;
   logic [LW-1:0]     level_nxt;
   logic              vout_q;
   logic [NB-1:0]     dout_q;
   logic              ovf_q;
   logic [DROP_W-1:0] drop_cnt;
   logic              full;
   logic              push;
   logic              pop;
   logic              drop;
   logic              bypass;
   logic [NB-1:0]     rdata;
   logic [NB-1:0]     head_nxt;

   assign full = (level == LW'(DEPTH));
   assign pop  = vout_q & bus.READY;
   assign push = bus.VIN & (~full | pop);
   assign drop = bus.VIN & full & ~pop;

   assign rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;

   // The incoming sample becomes the new head when nothing older survives this edge.
   assign bypass   = push & ((level == LW'(0)) | ((level == LW'(1)) & pop));
   assign head_nxt = bypass ? bus.DIN : rdata;

   always_comb begin
      level_nxt = level;
      if (push && !pop) begin
         level_nxt = level + LW'(1);
      end else if (pop && !push) begin
         level_nxt = level - LW'(1);
      end
   end

   fir_fifo_mem #(
      .NB    (NB),
      .DEPTH (DEPTH)
   ) u_mem (
      .CLK   (CLK),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (bus.DIN),
      .raddr (rd_ptr_nxt),
      .rdata (rdata)
   );

   // Pointers, occupancy FSM, registered show-ahead outputs and overflow tracking.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= ST_EMPTY;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         vout_q   <= 1'b0;
         dout_q   <= '0;
         ovf_q    <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         rd_ptr <= rd_ptr_nxt;
         level  <= level_nxt;
         vout_q <= (level_nxt != LW'(0));
         if (level_nxt != LW'(0)) begin
            dout_q <= head_nxt;
         end
         if (drop) begin
            ovf_q <= 1'b1;
            if (drop_cnt != '1) begin
               drop_cnt <= drop_cnt + DROP_W'(1);
            end
         end
         case (state)
            ST_EMPTY: begin
               if (push) begin
                  state <= ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               if (pop && !push && level == LW'(1)) begin
                  state <= ST_EMPTY;
               end else if (push && !pop && level == LW'(DEPTH - 1)) begin
                  state <= ST_FULL;
               end
            end
            ST_FULL: begin
               if (pop && !push) begin
                  state <= ST_ACTIVE;
               end
            end
            default: state <= ST_EMPTY;
         endcase
      end
   end

   assign bus.DOUT     = dout_q;
   assign bus.VOUT     = vout_q;
   assign bus.LEVEL    = level;
   assign bus.OVF      = ovf_q;
   assign bus.DROP_CNT = drop_cnt;

endmodule

// File: tb/tb_fir_out_fifo.sv
// Directed bench for fir_out_fifo: hand-computed vectors plus a small queue
// model for the long streaming run.
module tb_fir_out_fifo;
   import fir_pkg::*;

   logic CLK;
   logic RST;

   fir_out_fifo_if bus ();

   fir_out_fifo dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int vectors    = 0;
   int miscompares = 0;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, then settle before sampling.
   task automatic applyStimulus(input logic vin, input sample_t din, input logic ready);
      bus.VIN   = vin;
      bus.DIN   = din;
      bus.READY = ready;
      @(posedge CLK);
      #1;
   endtask

   task automatic doReset();
      RST       = 1'b1;
      bus.VIN   = 1'b0;
      bus.READY = 1'b0;
      bus.DIN   = '0;
      @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   sample_t fill [8];
   sample_t drain_exp [8];
   sample_t model_q [$];
   logic    v;
   logic    r;

   initial begin
      RST       = 1'b1;
      bus.VIN   = 1'b0;
      bus.READY = 1'b0;
      bus.DIN   = '0;
      repeat (2) @(posedge CLK);
      #1;
      checkOutput("rst_vout",  32'(bus.VOUT), 32'd0);
      checkOutput("rst_level", 32'(bus.LEVEL), 32'd0);
      checkOutput("rst_ovf",   32'(bus.OVF), 32'd0);
      checkOutput("rst_drop",  32'(bus.DROP_CNT), 32'd0);
      checkOutput("rst_dout",  32'(bus.DOUT), 32'd0);
      checkOutput("rst_state", 32'(dut.state), 32'(ST_EMPTY));
      RST = 1'b0;

      // Streaming with READY=1: each sample appears one cycle after its push.
      applyStimulus(1'b1, sample_t'(100), 1'b1);
      checkOutput("t1_dout0", 32'(bus.DOUT), 32'h064);
      checkOutput("t1_vout0", 32'(bus.VOUT), 32'd1);
      applyStimulus(1'b1, sample_t'(-5), 1'b1);
      checkOutput("t1_dout1", 32'(bus.DOUT), 32'h7FB);
      checkOutput("t1_lvl1",  32'(bus.LEVEL), 32'd1);
      applyStimulus(1'b1, sample_t'(1023), 1'b1);
      checkOutput("t1_dout2", 32'(bus.DOUT), 32'h3FF);
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("t1_level", 32'(bus.LEVEL), 32'd0);
      checkOutput("t1_vout",  32'(bus.VOUT), 32'd0);

      // Fill to full with READY=0, then overflow once.
      for (int i = 0; i < 8; i++) fill[i] = sample_t'(10 + 3 * i);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, fill[i], 1'b0);
         if (i == 0) checkOutput("t2_first", 32'(bus.DOUT), 32'd10);
      end
      checkOutput("t2_level", 32'(bus.LEVEL), 32'd8);
      checkOutput("t2_state", 32'(dut.state), 32'(ST_FULL));
      checkOutput("t2_dout",  32'(bus.DOUT), 32'd10);
      checkOutput("t2_ovf0",  32'(bus.OVF), 32'd0);
      applyStimulus(1'b1, sample_t'(999), 1'b0);
      checkOutput("t2_ovf",   32'(bus.OVF), 32'd1);
      checkOutput("t2_drop",  32'(bus.DROP_CNT), 32'd1);
      checkOutput("t2_lvl9",  32'(bus.LEVEL), 32'd8);
      checkOutput("t2_dout9", 32'(bus.DOUT), 32'd10);

      // Push and pop together while full: no drop, order kept.
      applyStimulus(1'b1, sample_t'(500), 1'b1);
      checkOutput("t3_level", 32'(bus.LEVEL), 32'd8);
      checkOutput("t3_drop",  32'(bus.DROP_CNT), 32'd1);
      checkOutput("t3_state", 32'(dut.state), 32'(ST_FULL));
      for (int i = 0; i < 7; i++) drain_exp[i] = fill[i + 1];
      drain_exp[7] = sample_t'(500);
      for (int k = 0; k < 8; k++) begin
         checkOutput($sformatf("t3_order%0d", k), 32'(bus.DOUT), 32'(drain_exp[k]));
         applyStimulus(1'b0, '0, 1'b1);
         if (k == 0) checkOutput("t3_active", 32'(dut.state), 32'(ST_ACTIVE));
      end
      checkOutput("t3_empty", 32'(bus.LEVEL), 32'd0);
      checkOutput("t3_st_e",  32'(dut.state), 32'(ST_EMPTY));

      // Consumer stalls: head and occupancy must not move.
      applyStimulus(1'b1, sample_t'(77), 1'b0);
      applyStimulus(1'b1, sample_t'(88), 1'b0);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, '0, 1'b0);
         checkOutput("t4_dout",  32'(bus.DOUT), 32'd77);
         checkOutput("t4_level", 32'(bus.LEVEL), 32'd2);
         checkOutput("t4_vout",  32'(bus.VOUT), 32'd1);
      end
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("t4_next", 32'(bus.DOUT), 32'd88);
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("t4_done", 32'(bus.LEVEL), 32'd0);

      // Long run against a queue model, clearing the sticky flag first.
      doReset();
      for (int i = 0; i < 80; i++) begin
         v = (i % 2) == 0;
         r = ((i / 2) % 2) == 1;
         checkOutput("t5_vout", 32'(bus.VOUT), 32'(model_q.size() != 0));
         if (r && model_q.size() != 0) begin
            checkOutput("t5_dout", 32'(bus.DOUT), 32'(model_q[0]));
            void'(model_q.pop_front());
         end
         if (v) model_q.push_back(sample_t'(i * 53 + 1));
         applyStimulus(v, sample_t'(i * 53 + 1), r);
      end
      for (int k = 0; k < 20 && model_q.size() != 0; k++) begin
         checkOutput("t5_drain", 32'(bus.DOUT), 32'(model_q[0]));
         void'(model_q.pop_front());
         applyStimulus(1'b0, '0, 1'b1);
      end
      checkOutput("t5_level", 32'(bus.LEVEL), 32'd0);
      checkOutput("t5_ovf",   32'(bus.OVF), 32'd0);
      checkOutput("t5_wrptr", 32'(dut.wr_ptr), 32'd0);
      checkOutput("t5_rdptr", 32'(dut.rd_ptr), 32'd0);

      // Asynchronous reset in mid-cycle with LEVEL=5 and OVF=1.
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, sample_t'(i + 1), 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1);
      checkOutput("t6_pre_lvl", 32'(bus.LEVEL), 32'd5);
      checkOutput("t6_pre_ovf", 32'(bus.OVF), 32'd1);
      bus.VIN   = 1'b1;
      bus.READY = 1'b1;
      #2;
      RST = 1'b1;
      #1;
      checkOutput("t6_vout",  32'(bus.VOUT), 32'd0);
      checkOutput("t6_level", 32'(bus.LEVEL), 32'd0);
      checkOutput("t6_ovf",   32'(bus.OVF), 32'd0);
      checkOutput("t6_drop",  32'(bus.DROP_CNT), 32'd0);
      checkOutput("t6_dout",  32'(bus.DOUT), 32'd0);
      applyStimulus(1'b1, sample_t'(3), 1'b1);
      checkOutput("t6_held", 32'(bus.LEVEL), 32'd0);
      RST = 1'b0;
      applyStimulus(1'b1, sample_t'(7), 1'b0);
      checkOutput("t6_dout7", 32'(bus.DOUT), 32'd7);
      checkOutput("t6_vout7", 32'(bus.VOUT), 32'd1);
      checkOutput("t6_lvl7",  32'(bus.LEVEL), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
